// File: rtl/dda_step_gen_multi.sv
// rtl/dda_step_gen_multi.sv - multi-channel DDA step generator with double-buffered period commands
// Optional: define STEP_POS_CNT_EN to add per-channel signed position counters on pos.
module dda_step_gen_multi #(
    parameter int NCH      = 4,
    parameter int CNT_W    = 10,
    parameter int CLK_DIV  = 200,
    parameter int SLOTS    = 500,
    parameter int ACC_W    = 11,
    parameter int ACC_INIT = SLOTS - 2,
    parameter int POS_W    = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     wr,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
    input  logic [CNT_W-1:0]                         wr_cnt,
    input  logic                                     wr_dir,
    input  logic                                     ovr_clr,
    output logic [NCH-1:0]                           step,
    output logic [NCH-1:0]                           dir,
    output logic [NCH-1:0]                           busy,
    output logic [NCH-1:0]                           ovr
`ifdef STEP_POS_CNT_EN
    ,
    output logic [NCH*POS_W-1:0]                     pos
`endif
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int H_W   = $clog2(2 * SLOTS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOTS);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    logic [PRE_W-1:0] r_presc;
    logic             w_tick;
    logic [CNT_W-1:0] w_cnt_in;

    assign w_tick   = (r_presc == PRE_W'(CLK_DIV - 1));
    assign w_cnt_in = (wr_cnt > CNT_MAX) ? CNT_MAX : wr_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_sh_cnt;
        logic             r_dir;
        logic             r_sh_dir;
        logic             r_sh_valid;
        logic             r_step;
        logic             r_busy;
        logic             r_ovr;
        logic [ACC_W-1:0] r_acc;
        logic [H_W-1:0]   r_h;
        logic             w_wr_here;
        logic             w_end;
        logic [ACC_W-1:0] w_sum;
`ifdef STEP_POS_CNT_EN
        logic [POS_W-1:0] r_pos;
        assign pos[g*POS_W +: POS_W] = r_pos;
`endif

        assign w_wr_here = wr && (wr_ch == CH_W'(g));
        assign w_end     = w_tick && (r_h == H_W'(2 * SLOTS - 1));
        assign w_sum     = r_acc + ACC_W'(r_cnt);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_sh_cnt   <= '0;
                r_dir      <= 1'b0;
                r_sh_dir   <= 1'b0;
                r_sh_valid <= 1'b0;
                r_step     <= 1'b0;
                r_busy     <= 1'b0;
                r_ovr      <= 1'b0;
                r_acc      <= '0;
                r_h        <= '0;
`ifdef STEP_POS_CNT_EN
                r_pos      <= '0;
`endif
            end else begin
                if (ovr_clr) begin
                    r_ovr <= 1'b0;
                end
                case (r_state)
                    S_IDLE: begin
                        // A fresh load ignores a coincident tick; h=0 waits for the next one.
                        if (w_wr_here) begin
                            r_cnt   <= w_cnt_in;
                            r_dir   <= wr_dir;
                            r_acc   <= ACC_W'(ACC_INIT);
                            r_h     <= '0;
                            r_step  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (w_wr_here && r_sh_valid) begin
                            r_ovr <= 1'b1;
                        end
                        if (w_end) begin
                            r_step <= 1'b0;
                            r_acc  <= ACC_W'(ACC_INIT);
                            r_h    <= '0;
                            // A write landing on the period-end edge bypasses the shadow.
                            if (w_wr_here) begin
                                r_cnt      <= w_cnt_in;
                                r_dir      <= wr_dir;
                                r_sh_valid <= 1'b0;
                            end else if (r_sh_valid) begin
                                r_cnt      <= r_sh_cnt;
                                r_dir      <= r_sh_dir;
                                r_sh_valid <= 1'b0;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            if (w_wr_here) begin
                                r_sh_cnt   <= w_cnt_in;
                                r_sh_dir   <= wr_dir;
                                r_sh_valid <= 1'b1;
                            end
                            if (w_tick) begin
                                r_h <= r_h + 1'b1;
                                if (!r_h[0]) begin
                                    if (w_sum >= ACC_W'(SLOTS)) begin
                                        r_acc  <= w_sum - ACC_W'(SLOTS);
                                        r_step <= 1'b1;
`ifdef STEP_POS_CNT_EN
                                        r_pos  <= r_dir ? (r_pos + 1'b1) : (r_pos - 1'b1);
`endif
                                    end else begin
                                        r_acc  <= w_sum;
                                        r_step <= 1'b0;
                                    end
                                end else begin
                                    r_step <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_step  <= 1'b0;
                    end
                endcase
            end
        end

        assign step[g] = r_step;
        assign dir[g]  = r_dir;
        assign busy[g] = r_busy;
        assign ovr[g]  = r_ovr;
    end

endmodule
